// File: rtl/lab4_pkg.sv
// Shared types and field positions for the Lab 4 fetch/execute controller.
package lab4_pkg;
   localparam int IMEM_DEPTH = 64;
   localparam int IMEM_AW    = 6;
   localparam int IW         = 12;
   localparam int RF_AW      = 3;

   localparam int OP_MSB  = 11;
   localparam int OP_LSB  = 9;
   localparam int RD_MSB  = 8;
   localparam int RD_LSB  = 6;
   localparam int RA_MSB  = 5;
   localparam int RA_LSB  = 3;
   localparam int RB_MSB  = 2;
   localparam int RB_LSB  = 0;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_LDI  = 3'b100,
      OP_BRZ  = 3'b101,
      OP_JMP  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_LOAD      = 3'd1,
      S_EXEC      = 3'd2,
      S_STEP_WAIT = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD      = 2'b00,
      ALU_SUB      = 2'b01,
      ALU_AND      = 2'b10,
      ALU_PASS_IMM = 2'b11
   } alu_op_t;

   function automatic logic writes_rf(input opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_LDI);
   endfunction

   // Non-writing opcodes default to ADD; rf_we alone decides whether it matters.
   function automatic alu_op_t alu_op_of(input opcode_t op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_LDI:  return ALU_PASS_IMM;
         default: return ALU_ADD;
      endcase
   endfunction
endpackage

// File: rtl/key_debounce.sv
// KEY0 conditioning: two-flop synchronizer, low-sample counter, one-shot press.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          key_meta;
   logic          key_sync;
   logic [CW-1:0] cnt;

   // Counter saturates while held, so only a high sample can re-arm the pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
         press    <= 1'b0;
         if (key_sync) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt   <= cnt + CNT_ONE;
            press <= (cnt == CNT_MAX - CNT_ONE);
         end
      end
   end
endmodule

// File: rtl/lab4_sequencer.sv
// Fetch/execute controller: pc, ir, decode strobes and free-run/single-step policy.
//
// state       | meaning
// FETCH     0 | ROM address = pc
// LOAD      1 | ROM data captured into ir
// EXEC      2 | rf_we pulse, pc update
// STEP_WAIT 3 | single-step park until an accepted press
// HALT      4 | terminal until reset
module lab4_sequencer
   import lab4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step_mode,
   input  logic               key_n,
   output logic [IMEM_AW-1:0] mem_addr,
   input  logic [IW-1:0]      mem_rdata,
   output logic [IW-1:0]      ir,
   input  logic               zero,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_waddr,
   output logic [RF_AW-1:0]   rf_raddr_a,
   output logic [RF_AW-1:0]   rf_raddr_b,
   output logic [1:0]         alu_op,
   output logic [5:0]         imm,
   output logic [IMEM_AW-1:0] pc,
   output logic [2:0]         state_dbg,
   output logic               halted
);
   state_t  state;
   logic    we_q;
   logic    press;
   opcode_t op_cur;
   opcode_t op_next;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n),
      .press (press)
   );

   assign op_cur  = opcode_t'(ir[OP_MSB:OP_LSB]);
   assign op_next = opcode_t'(mem_rdata[OP_MSB:OP_LSB]);

   assign mem_addr   = pc;
   assign state_dbg  = state;
   assign rf_waddr   = ir[RD_MSB:RD_LSB];
   assign rf_raddr_a = ir[RA_MSB:RA_LSB];
   assign rf_raddr_b = ir[RB_MSB:RB_LSB];
   assign imm        = ir[IMM_MSB:IMM_LSB];
   assign alu_op     = alu_op_of(op_cur);
   // A reset landing on EXEC must not let the register file write on that edge.
   assign rf_we      = we_q & rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_FETCH;
         pc     <= '0;
         ir     <= '0;
         we_q   <= 1'b0;
         halted <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state)
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               ir    <= mem_rdata;
               we_q  <= writes_rf(op_next);
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (op_cur)
                  OP_BRZ:  pc <= zero ? imm : pc + 6'd1;
                  OP_JMP:  pc <= imm;
                  OP_HALT: pc <= pc;
                  default: pc <= pc + 6'd1;
               endcase
               if (op_cur == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else if (step_mode) begin
                  state <= S_STEP_WAIT;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_STEP_WAIT: if (press || !step_mode) state <= S_FETCH;
            S_HALT:      halted <= 1'b1;
            default:     state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_lab4_sequencer.sv
// Self-checking bench for lab4_sequencer with a synchronous ROM model and an
// instruction-level reference model.
module tb_lab4_sequencer;
   logic        clk;
   logic        rst_n;
   logic        step_mode;
   logic        key_n;
   logic [5:0]  mem_addr;
   logic [11:0] mem_rdata;
   logic [11:0] ir;
   logic        zero;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [2:0]  rf_raddr_a;
   logic [2:0]  rf_raddr_b;
   logic [1:0]  alu_op;
   logic [5:0]  imm;
   logic [5:0]  pc;
   logic [2:0]  state_dbg;
   logic        halted;

   logic [11:0] rom [0:63];
   int total = 0;
   int bad   = 0;

   lab4_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_mode  (step_mode),
      .key_n      (key_n),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .ir         (ir),
      .zero       (zero),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .alu_op     (alu_op),
      .imm        (imm),
      .pc         (pc),
      .state_dbg  (state_dbg),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= rom[mem_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [5:0] low);
      return {op, rd, low};
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 12'h000;
   endtask

   // Leaves the bench mid-cycle 0 (first FETCH after reset).
   task automatic do_reset();
      rst_n = 1'b0;
      key_n = 1'b1;
      tick(1);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_rom();
      rom[0] = 12'h845;
      step_mode = 1'b0;
      do_reset();
      tick(4);
      do_reset();
      total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      total++; if (pc !== 6'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
      total++; if (ir !== 12'h000) begin bad++; $display("FAIL reset_ir got=%h exp=000", ir); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
      total++; if (mem_addr !== 6'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
   endtask

   task automatic test_ldi();
      clear_rom();
      rom[0] = enc(3'b100, 3'd1, 6'd5);
      step_mode = 1'b0;
      do_reset();
      total++; if (mem_addr !== 6'd0) begin bad++; $display("FAIL ldi_addr got=%0d exp=0", mem_addr); end
      tick(1);
      total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL ldi_load_state got=%0d exp=1", state_dbg); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ldi_load_we got=%b exp=0", rf_we); end
      tick(1);
      total++; if (ir !== 12'h845) begin bad++; $display("FAIL ldi_ir got=%h exp=845", ir); end
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ldi_we got=%b exp=1", rf_we); end
      total++; if (rf_waddr !== 3'd1) begin bad++; $display("FAIL ldi_waddr got=%0d exp=1", rf_waddr); end
      total++; if (alu_op !== 2'b11) begin bad++; $display("FAIL ldi_alu_op got=%b exp=11", alu_op); end
      total++; if (imm !== 6'd5) begin bad++; $display("FAIL ldi_imm got=%0d exp=5", imm); end
      tick(1);
      total++; if (pc !== 6'd1) begin bad++; $display("FAIL ldi_pc got=%0d exp=1", pc); end
      total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL ldi_next_state got=%0d exp=0", state_dbg); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ldi_we_after got=%b exp=0", rf_we); end
   endtask

   task automatic test_alu_prog();
      logic       exp_we;
      logic [1:0] exp_op;
      int         idx;
      clear_rom();
      rom[0] = enc(3'b001, 3'd2, 6'o13);
      rom[1] = enc(3'b010, 3'd3, 6'o21);
      rom[2] = enc(3'b011, 3'd4, 6'o35);
      rom[3] = enc(3'b110, 3'd0, 6'd0);
      step_mode = 1'b0;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         idx    = (c / 3) % 4;
         exp_we = (c % 3 == 2) && (idx < 3);
         exp_op = 2'(idx);
         total++; if (rf_we !== exp_we) begin bad++; $display("FAIL alu_we c=%0d got=%b exp=%b", c, rf_we, exp_we); end
         if (c % 3 == 0) begin
            total++; if (mem_addr !== 6'(idx)) begin bad++; $display("FAIL alu_addr c=%0d got=%0d exp=%0d", c, mem_addr, idx); end
         end
         if (exp_we) begin
            total++; if (alu_op !== exp_op) begin bad++; $display("FAIL alu_op c=%0d got=%b exp=%b", c, alu_op, exp_op); end
         end
         tick(1);
      end
   endtask

   task automatic test_branch_wrap();
      clear_rom();
      rom[0]  = enc(3'b101, 3'd0, 6'd10);
      rom[10] = enc(3'b101, 3'd0, 6'd20);
      rom[11] = enc(3'b110, 3'd0, 6'd63);
      rom[63] = 12'h000;
      step_mode = 1'b0;
      zero = 1'b1;
      do_reset();
      tick(3);
      total++; if (pc !== 6'd10) begin bad++; $display("FAIL brz_taken got=%0d exp=10", pc); end
      zero = 1'b0;
      tick(3);
      total++; if (pc !== 6'd11) begin bad++; $display("FAIL brz_not_taken got=%0d exp=11", pc); end
      tick(3);
      total++; if (pc !== 6'd63) begin bad++; $display("FAIL jmp_63 got=%0d exp=63", pc); end
      tick(3);
      total++; if (pc !== 6'd0) begin bad++; $display("FAIL pc_wrap got=%0d exp=0", pc); end
   endtask

   task automatic test_random();
      logic [11:0] w;
      logic [2:0]  op;
      logic        exp_we;
      logic [1:0]  exp_op;
      int          pc_m;
      clear_rom();
      for (int i = 0; i < 64; i++) begin
         w = 12'($urandom);
         w[11:9] = 3'($urandom_range(0, 6));
         rom[i] = w;
      end
      step_mode = 1'b0;
      do_reset();
      pc_m = 0;
      for (int n = 0; n < 150; n++) begin
         total++; if (mem_addr !== 6'(pc_m)) begin bad++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, mem_addr, pc_m); end
         total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rnd_fetch n=%0d got=%0d exp=0", n, state_dbg); end
         tick(1);
         zero = 1'($urandom);
         tick(1);
         w      = rom[pc_m];
         op     = w[11:9];
         exp_we = (op >= 3'd1) && (op <= 3'd4);
         exp_op = (op == 3'd4) ? 2'd3 : 2'(op - 3'd1);
         total++; if (ir !== w) begin bad++; $display("FAIL rnd_ir n=%0d got=%h exp=%h", n, ir, w); end
         total++; if (rf_we !== exp_we) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, rf_we, exp_we); end
         total++; if ({rf_waddr, rf_raddr_a, rf_raddr_b} !== w[8:0]) begin bad++; $display("FAIL rnd_regs n=%0d got=%o exp=%o", n, {rf_waddr, rf_raddr_a, rf_raddr_b}, w[8:0]); end
         if (exp_we) begin
            total++; if (alu_op !== exp_op) begin bad++; $display("FAIL rnd_alu n=%0d got=%b exp=%b", n, alu_op, exp_op); end
         end
         if (op == 3'd5)      pc_m = zero ? int'(w[5:0]) : (pc_m + 1) % 64;
         else if (op == 3'd6) pc_m = int'(w[5:0]);
         else                 pc_m = (pc_m + 1) % 64;
         tick(1);
      end
   endtask

   task automatic test_step();
      clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = enc(3'b100, 3'(i), 6'(i));
      step_mode = 1'b1;
      do_reset();
      tick(3);
      total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL step_park got=%0d exp=3", state_dbg); end
      total++; if (pc !== 6'd1) begin bad++; $display("FAIL step_pc1 got=%0d exp=1", pc); end
      key_n = 1'b0; tick(3); key_n = 1'b1; tick(10);
      total++; if (pc !== 6'd1 || state_dbg !== 3'd3) begin bad++; $display("FAIL step_glitch pc=%0d st=%0d exp pc=1 st=3", pc, state_dbg); end
      key_n = 1'b0;
      tick(6);
      total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL step_latency_early got=%0d exp=3", state_dbg); end
      tick(1);
      total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL step_latency got=%0d exp=0", state_dbg); end
      tick(3); key_n = 1'b1; tick(10);
      total++; if (pc !== 6'd2 || state_dbg !== 3'd3) begin bad++; $display("FAIL step_one pc=%0d st=%0d exp pc=2 st=3", pc, state_dbg); end
      key_n = 1'b0; tick(50); key_n = 1'b1; tick(10);
      total++; if (pc !== 6'd3 || state_dbg !== 3'd3) begin bad++; $display("FAIL step_held pc=%0d st=%0d exp pc=3 st=3", pc, state_dbg); end
      step_mode = 1'b0;
      tick(1);
      total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL step_release got=%0d exp=0", state_dbg); end
      step_mode = 1'b1;
      tick(3);
      total++; if (pc !== 6'd4 || state_dbg !== 3'd3) begin bad++; $display("FAIL step_remode pc=%0d st=%0d exp pc=4 st=3", pc, state_dbg); end
   endtask

   task automatic test_halt();
      clear_rom();
      rom[2] = enc(3'b111, 3'd0, 6'd0);
      rom[3] = enc(3'b100, 3'd1, 6'd1);
      step_mode = 1'b0;
      do_reset();
      tick(9);
      total++; if (state_dbg !== 3'd4 || halted !== 1'b1 || pc !== 6'd2) begin bad++; $display("FAIL halt_enter st=%0d h=%b pc=%0d exp st=4 h=1 pc=2", state_dbg, halted, pc); end
      step_mode = 1'b1; key_n = 1'b0; tick(10); key_n = 1'b1;
      step_mode = 1'b0; tick(5); step_mode = 1'b1; tick(5); step_mode = 1'b0; tick(2);
      total++; if (state_dbg !== 3'd4 || halted !== 1'b1 || pc !== 6'd2) begin bad++; $display("FAIL halt_hold st=%0d h=%b pc=%0d exp st=4 h=1 pc=2", state_dbg, halted, pc); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL halt_we got=%b exp=0", rf_we); end
      rst_n = 1'b0; tick(1); rst_n = 1'b1;
      total++; if (state_dbg !== 3'd0 || halted !== 1'b0 || pc !== 6'd0) begin bad++; $display("FAIL halt_reset st=%0d h=%b pc=%0d exp st=0 h=0 pc=0", state_dbg, halted, pc); end
   endtask

   task automatic test_reset_mid_exec();
      clear_rom();
      rom[0] = enc(3'b001, 3'd1, 6'o23);
      step_mode = 1'b0;
      do_reset();
      tick(2);
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL midexec_pre_we got=%b exp=1", rf_we); end
      rst_n = 1'b0;
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midexec_we got=%b exp=0", rf_we); end
      @(negedge clk);
      rst_n = 1'b1;
      total++; if (state_dbg !== 3'd0 || pc !== 6'd0 || rf_we !== 1'b0) begin bad++; $display("FAIL midexec_after st=%0d pc=%0d we=%b exp st=0 pc=0 we=0", state_dbg, pc, rf_we); end
   endtask

   initial begin
      rst_n = 1'b0;
      step_mode = 1'b0;
      key_n = 1'b1;
      zero = 1'b0;
      clear_rom();
      tick(2);
      test_reset();
      test_ldi();
      test_alu_prog();
      test_branch_wrap();
      test_random();
      test_step();
      test_halt();
      test_reset_mid_exec();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
